wm_cycle_controller: RTL and testbench

Sequential cycle controller placed directly downstream of a washing-machine settings unit. It consumes the registered wash, rinse, spin and cloth settings and, on a start request, runs one timed wash program: FILL, WASH, DRAIN, RINSE, SPIN, DONE. It drives the valve, motor and pump enables and reports phase and remaining time. Both washing-machine instances in the top level each get one controller.

---
 rtl/wm_cycle_controller.sv | 200 ++++++++++++++++++++
 tb/tb_wm_cycle_controller.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wm_cycle_controller.sv
// Washing-machine program sequencer: FILL, WASH, DRAIN, RINSE, SPIN, DONE on a prescaled
// tick, with pause freeze, abort via early drain, and registered actuator enables.
module wm_cycle_controller #(
  parameter int unsigned TICK_DIV    = 4,
  parameter int unsigned DRAIN_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       pause,
  input  logic       abort,
  input  logic [4:0] wash_in,
  input  logic [4:0] rinse_in,
  input  logic [4:0] spin_in,
  input  logic [4:0] cloth_in,
  output logic [2:0] phase,
  output logic [4:0] remaining,
  output logic       busy,
  output logic       valve,
  output logic       motor,
  output logic       pump,
  output logic       done,
  output logic       aborted
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FILL  = 3'd1,
    WASH  = 3'd2,
    DRAIN = 3'd3,
    RINSE = 3'd4,
    SPIN  = 3'd5,
    DONE  = 3'd6
  } phase_t;

  localparam logic [7:0] PRESC_MAX = 8'(TICK_DIV - 1);
  localparam logic [4:0] DRAIN_LEN = 5'(DRAIN_TICKS);

  phase_t     phase_q, phase_d;
  logic [4:0] remaining_q, remaining_d;
  logic [7:0] presc_q, presc_d;
  logic [4:0] wash_q, wash_d;
  logic [4:0] rinse_q, rinse_d;
  logic [4:0] spin_q, spin_d;
  logic [4:0] cloth_q, cloth_d;
  logic       aborted_q, aborted_d;
  logic       busy_q, valve_q, motor_q, pump_q, done_q;

  logic       tick;
  logic       hold;
  logic       advance;
  phase_t     nxt;

  // Next phase with nonzero duration; an aborted program leaves DRAIN straight to DONE.
  function automatic phase_t next_phase(input phase_t p, input logic [4:0] w,
                                        input logic [4:0] r, input logic [4:0] s,
                                        input logic early);
    phase_t n;
    n = DONE;
    case (p)
      FILL:    n = (w != 5'd0) ? WASH : DRAIN;
      WASH:    n = DRAIN;
      DRAIN:   n = early ? DONE : (r != 5'd0) ? RINSE : (s != 5'd0) ? SPIN : DONE;
      RINSE:   n = (s != 5'd0) ? SPIN : DONE;
      default: n = DONE;
    endcase
    return n;
  endfunction

  function automatic logic [4:0] duration(input phase_t p, input logic [4:0] c,
                                          input logic [4:0] w, input logic [4:0] r,
                                          input logic [4:0] s);
    logic [4:0] d;
    d = 5'd0;
    case (p)
      FILL:    d = {2'b00, c[4:2]} + 5'd1;
      WASH:    d = w;
      DRAIN:   d = DRAIN_LEN;
      RINSE:   d = r;
      SPIN:    d = s;
      default: d = 5'd0;
    endcase
    return d;
  endfunction

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    phase_d     = phase_q;
    remaining_d = remaining_q;
    presc_d     = presc_q;
    wash_d      = wash_q;
    rinse_d     = rinse_q;
    spin_d      = spin_q;
    cloth_d     = cloth_q;
    aborted_d   = aborted_q;
    hold        = 1'b0;
    advance     = 1'b0;
    tick        = (presc_q == PRESC_MAX);
    nxt         = next_phase(phase_q, wash_q, rinse_q, spin_q, aborted_q | abort);

    case (phase_q)
      IDLE: begin
        if (start && !abort && (cloth_in != 5'd0)) begin
          wash_d      = wash_in;
          rinse_d     = rinse_in;
          spin_d      = spin_in;
          cloth_d     = cloth_in;
          aborted_d   = 1'b0;
          phase_d     = FILL;
          remaining_d = duration(FILL, cloth_in, wash_in, rinse_in, spin_in);
          presc_d     = 8'd0;
        end
      end
      DONE: begin
        phase_d     = IDLE;
        remaining_d = 5'd0;
        presc_d     = 8'd0;
      end
      default: begin
        if (abort) begin
          aborted_d = 1'b1;
          if (phase_q == SPIN) begin
            phase_d     = DONE;
            remaining_d = 5'd0;
            presc_d     = 8'd0;
          end else if (phase_q == DRAIN) begin
            advance = 1'b1;
          end else begin
            phase_d     = DRAIN;
            remaining_d = DRAIN_LEN;
            presc_d     = 8'd0;
          end
        end else if (pause) begin
          hold = 1'b1;
        end else begin
          advance = 1'b1;
        end

        if (advance) begin
          if (tick) begin
            presc_d = 8'd0;
            if (remaining_q == 5'd1) begin
              phase_d     = nxt;
              remaining_d = duration(nxt, cloth_q, wash_q, rinse_q, spin_q);
            end else begin
              remaining_d = remaining_q - 5'd1;
            end
          end else begin
            presc_d = presc_q + 8'd1;
          end
        end
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values, regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q     <= IDLE;
      remaining_q <= 5'd0;
      presc_q     <= 8'd0;
      wash_q      <= 5'd0;
      rinse_q     <= 5'd0;
      spin_q      <= 5'd0;
      cloth_q     <= 5'd0;
      aborted_q   <= 1'b0;
      busy_q      <= 1'b0;
      valve_q     <= 1'b0;
      motor_q     <= 1'b0;
      pump_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      remaining_q <= remaining_d;
      presc_q     <= presc_d;
      wash_q      <= wash_d;
      rinse_q     <= rinse_d;
      spin_q      <= spin_d;
      cloth_q     <= cloth_d;
      aborted_q   <= aborted_d;
      busy_q      <= (phase_d inside {FILL, WASH, DRAIN, RINSE, SPIN});
      valve_q     <= !hold && (phase_d inside {FILL, RINSE});
      motor_q     <= !hold && (phase_d inside {WASH, RINSE, SPIN});
      pump_q      <= !hold && (phase_d inside {DRAIN, SPIN});
      done_q      <= (phase_d == DONE);
    end
  end

  assign phase     = phase_q;
  assign remaining = remaining_q;
  assign busy      = busy_q;
  assign valve     = valve_q;
  assign motor     = motor_q;
  assign pump      = pump_q;
  assign done      = done_q;
  assign aborted   = aborted_q;

endmodule

// File: tb/tb_wm_cycle_controller.sv
// Scoreboard bench for wm_cycle_controller: a program-level model predicts phase order,
// busy length and abort flag per program; a negedge monitor checks the DUT against them.
module tb_wm_cycle_controller;

  localparam int TD = 4;
  localparam int DT = 2;

  logic       clk = 1'b0;
  logic       rst, start, pause, abort;
  logic [4:0] wash_in, rinse_in, spin_in, cloth_in;
  logic [2:0] phase;
  logic [4:0] remaining;
  logic       busy, valve, motor, pump, done, aborted;

  wm_cycle_controller #(.TICK_DIV(TD), .DRAIN_TICKS(DT)) dut (
    .clk(clk), .rst(rst), .start(start), .pause(pause), .abort(abort),
    .wash_in(wash_in), .rinse_in(rinse_in), .spin_in(spin_in), .cloth_in(cloth_in),
    .phase(phase), .remaining(remaining), .busy(busy), .valve(valve), .motor(motor),
    .pump(pump), .done(done), .aborted(aborted)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int d_fill, d_wash, d_drain, d_rinse, d_spin;
    int base;       // unpaused, unaborted busy cycles
    int exp_busy;
    int exp_seq;    // busy phases in order of appearance, 3 bits each
    bit exp_abort;
  } item_t;

  item_t sb[$];

  function automatic int dur_of(input item_t it, input int p);
    case (p)
      1: return it.d_fill;
      2: return it.d_wash;
      3: return it.d_drain;
      4: return it.d_rinse;
      5: return it.d_spin;
      default: return 0;
    endcase
  endfunction

  // mode 0: plain; mode 1: pause of `param` cycles; mode 2: abort sampled at edge `param` after start.
  function automatic item_t plan(input int w, input int r, input int s, input int c,
                                 input int mode, input int param);
    item_t it;
    int ph[5];
    int len[5];
    int n, t, acc, j, st;
    it.d_fill = ((c >> 2) & 7) + 1;
    it.d_wash = w;
    it.d_drain = DT;
    it.d_rinse = r;
    it.d_spin = s;
    n = 0;
    t = 0;
    for (int p = 1; p <= 5; p++) begin
      if (dur_of(it, p) > 0) begin
        ph[n] = p;
        len[n] = dur_of(it, p) * TD;
        t += len[n];
        n++;
      end
    end
    it.base = t;
    it.exp_abort = (mode == 2);
    it.exp_seq = 0;
    if (mode != 2) begin
      for (int i = 0; i < n; i++) it.exp_seq = (it.exp_seq << 3) | ph[i];
      it.exp_busy = (mode == 1) ? t + param : t;
    end else begin
      acc = 0;
      j = 0;
      st = 0;
      for (int i = 0; i < n; i++) begin
        if ((param - 1) >= acc && (param - 1) < acc + len[i]) begin
          j = i;
          st = acc;
        end
        acc += len[i];
      end
      for (int i = 0; i <= j; i++) it.exp_seq = (it.exp_seq << 3) | ph[i];
      if (ph[j] == 3) it.exp_busy = st + len[j];
      else if (ph[j] == 5) it.exp_busy = param;
      else begin
        it.exp_busy = param + DT * TD;
        it.exp_seq = (it.exp_seq << 3) | 3;
      end
    end
    return it;
  endfunction

  function automatic logic [3:0] act_exp(input int ph, input bit hold);
    logic v, m, p, b;
    v = (ph == 1 || ph == 4);
    m = (ph == 2 || ph == 4 || ph == 5);
    p = (ph == 3 || ph == 5);
    b = (ph >= 1 && ph <= 5);
    if (hold) begin
      v = 1'b0;
      m = 1'b0;
      p = 1'b0;
    end
    return {v, m, p, b};
  endfunction

  // Monitor state
  bit    mon_en = 1'b0;
  bit    hold_exp = 1'b0;
  bit    prev_done = 1'b0;
  int    pre_ph, pre_rem;
  int    busy_cnt = 0, seq = 0, last_ph = 0;
  int    ph;
  item_t it_mon;

  always @(posedge clk) begin
    hold_exp = (phase >= 3'd1 && phase <= 3'd5) && pause && !abort && !rst;
    pre_ph = int'(phase);
    pre_rem = int'(remaining);
  end

  always @(negedge clk) begin
    if (mon_en) begin
      ph = int'(phase);
      check("actuators", int'({valve, motor, pump, busy}), int'(act_exp(ph, hold_exp)));
      if (hold_exp) check("pause_freeze", int'({phase, remaining}), (pre_ph << 5) | pre_rem);
      if (ph >= 1 && ph <= 5) begin
        busy_cnt++;
        if (ph != last_ph) begin
          seq = (seq << 3) | ph;
          if (sb.size() > 0) check("entry_remaining", int'(remaining), dur_of(sb[0], ph));
        end
      end
      if (prev_done) check("done_to_idle", ph, 0);
      if (done) begin
        check("done_state", int'({phase, remaining, busy}), int'({3'd6, 5'd0, 1'b0}));
        if (sb.size() == 0) begin
          check("unexpected_done", 0, 1);
        end else begin
          it_mon = sb.pop_front();
          check("busy_cycles", busy_cnt, it_mon.exp_busy);
          check("phase_order", seq, it_mon.exp_seq);
          check("aborted_flag", int'(aborted), int'(it_mon.exp_abort));
        end
        busy_cnt = 0;
        seq = 0;
      end
      last_ph = ph;
      prev_done = done;
    end
  end

  task automatic scramble();
    wash_in = 5'($urandom);
    rinse_in = 5'($urandom);
    spin_in = 5'($urandom);
    cloth_in = 5'($urandom);
  endtask

  task automatic wait_done(input string name, input bit scr);
    int n;
    n = 0;
    while (!done && n < 4000) begin
      @(negedge clk);
      n++;
      if (scr) scramble();
    end
    if (!done) check(name, 0, 1);
  endtask

  // p0: cycles after start before pause rises (mode 1).
  task automatic run_program(input int w, input int r, input int s, input int c,
                             input int mode, input int param, input int p0, input bit scr);
    item_t it;
    it = plan(w, r, s, c, mode, param);
    @(negedge clk);
    wash_in = 5'(w);
    rinse_in = 5'(r);
    spin_in = 5'(s);
    cloth_in = 5'(c);
    start = 1'b1;
    sb.push_back(it);
    @(negedge clk);
    start = 1'b0;
    if (scr) scramble();
    if (mode == 1) begin
      repeat (p0) @(negedge clk);
      pause = 1'b1;
      repeat (param) @(negedge clk);
      pause = 1'b0;
    end else if (mode == 2) begin
      repeat (param - 1) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
    end
    wait_done("done_timeout", scr);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    mon_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("reset_state",
          int'({phase, remaining, busy, valve, motor, pump, done, aborted}), 0);
    rst = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    start = 1'b0;
    sb.delete();
    busy_cnt = 0;
    seq = 0;
    last_ph = 0;
    prev_done = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    item_t tmp;
    int w, r, s, c, mode, t, n;
    rst = 1'b1;
    start = 1'b0;
    pause = 1'b0;
    abort = 1'b0;
    wash_in = '0;
    rinse_in = '0;
    spin_in = '0;
    cloth_in = '0;
    repeat (2) @(negedge clk);
    apply_reset();

    // Normal, skip, pause mid-WASH, abort in RINSE, clearing start, abort in SPIN.
    run_program(2, 1, 3, 8, 0, 0, 0, 1'b0);
    run_program(0, 0, 0, 3, 0, 0, 0, 1'b0);
    run_program(2, 1, 3, 8, 1, 10, 13, 1'b1);
    run_program(2, 1, 3, 8, 2, 30, 0, 1'b0);
    check("aborted_sticky_idle", int'(aborted), 1);
    run_program(2, 1, 3, 8, 0, 0, 0, 1'b0);
    run_program(2, 1, 3, 8, 2, 40, 0, 1'b0);

    // Rejected starts: empty drum, and start together with abort.
    cloth_in = 5'd0;
    start = 1'b1;
    repeat (5) @(negedge clk);
    check("reject_empty", int'({phase, busy}), 0);
    cloth_in = 5'd8;
    abort = 1'b1;
    repeat (5) @(negedge clk);
    check("reject_abort", int'({phase, busy}), 0);
    start = 1'b0;
    abort = 1'b0;
    @(negedge clk);
    check("aborted_kept_on_reject", int'(aborted), 1);
    apply_reset();

    repeat (25) begin
      w = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
      r = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
      s = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 6));
      c = int'($urandom_range(1, 31));
      mode = int'($urandom_range(0, 2));
      tmp = plan(w, r, s, c, 0, 0);
      t = tmp.base;
      if (mode == 1) run_program(w, r, s, c, 1, int'($urandom_range(1, 12)),
                                 int'($urandom_range(0, t - 1)), 1'b1);
      else if (mode == 2) run_program(w, r, s, c, 2, int'($urandom_range(1, t)), 0, 1'b1);
      else run_program(w, r, s, c, 0, 0, 0, 1'b1);
    end

    // Start held through DONE: exactly one IDLE cycle between programs.
    tmp = plan(3, 2, 1, 12, 0, 0);
    sb.push_back(tmp);
    sb.push_back(tmp);
    @(negedge clk);
    wash_in = 5'd3;
    rinse_in = 5'd2;
    spin_in = 5'd1;
    cloth_in = 5'd12;
    start = 1'b1;
    wait_done("b2b_first_timeout", 1'b0);
    @(negedge clk);
    check("b2b_idle_gap", int'(phase), 0);
    @(negedge clk);
    check("b2b_restart", int'(phase), 1);
    start = 1'b0;
    wait_done("b2b_second_timeout", 1'b0);
    @(negedge clk);

    // Reset during SPIN while paused.
    wash_in = 5'd2;
    rinse_in = 5'd1;
    spin_in = 5'd3;
    cloth_in = 5'd8;
    start = 1'b1;
    sb.push_back(plan(2, 1, 3, 8, 0, 0));
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (phase != 3'd5 && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("reach_spin", int'(phase), 5);
    pause = 1'b1;
    repeat (3) @(negedge clk);
    check("spin_paused_motor", int'({motor, pump}), 0);
    apply_reset();
    repeat (2) @(negedge clk);
    check("idle_after_reset", int'({phase, busy}), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
